// File: rtl/conv_weight_kernel_buffer.sv
// conv_weight_kernel_buffer
// Captures the free-running conv weight stream after a layer request and
// regroups it into one kernel set (IN_CHANNELS x K x K words) per output
// channel. Sets are handed to the conv engine over a valid/ready handshake
// from a ping-pong pair of banks. A word arriving when its set would land
// in a still-full bank is dropped and the sticky overflow flag is raised.
// Optional feature macro: WKB_CHECKSUM_EN (running 32-bit sum of all
// accepted weight words, cleared when a layer is requested).
module conv_weight_kernel_buffer #(
   parameter int DATA_WIDTH   = 16,
   parameter int IN_CHANNELS  = 4,
   parameter int OUT_CHANNELS = 64,
   parameter int KERNEL_SIZE  = 3,
   localparam int KERNEL_ELEM_NUM = KERNEL_SIZE * KERNEL_SIZE,
   localparam int KPC             = IN_CHANNELS * KERNEL_ELEM_NUM
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_layer,
   output logic                              start_stream,
   input  logic                              weight_valid,
   input  logic [DATA_WIDTH-1:0]             weight_data,
   output logic                              kernel_valid,
   input  logic                              kernel_ready,
   output logic [KPC*DATA_WIDTH-1:0]         kernel_data,
   output logic [$clog2(OUT_CHANNELS)-1:0]   kernel_oc,
   output logic                              layer_done,
   output logic                              busy,
   output logic                              overflow,
   output logic [31:0]                       weight_checksum
);

   localparam int IDX_W = $clog2(KPC);
   localparam int OC_W  = $clog2(OUT_CHANNELS);
   localparam int WOC_W = $clog2(OUT_CHANNELS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KPC - 1);
   localparam logic [WOC_W-1:0] WOC_LAST = WOC_W'(OUT_CHANNELS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             state_r;
   logic [1:0]         full_r;
   logic               wr_bank_r;
   logic               rd_bank_r;
   logic [IDX_W-1:0]   wr_idx_r;
   logic [WOC_W-1:0]   wr_oc_r;
   logic [OC_W-1:0]    rd_oc_r;
   logic               drop_r;
   logic               start_stream_r;
   logic               kernel_valid_r;
   logic               layer_done_r;
   logic               busy_r;
   logic               overflow_r;

   // Bank storage; contents are deliberately left out of reset.
   logic [DATA_WIDTH-1:0] bank_r [2][KPC];

   logic               accept_s;
   logic               drop_s;
   logic               set_done_s;
   logic               consume_s;
   logic [1:0]         full_next_s;
   logic               rd_bank_next_s;
   logic [KPC*DATA_WIDTH-1:0] kernel_data_s;

   // Per-word decisions and next-state of the bank-full flags.
   always_comb begin
      accept_s       = 1'b0;
      drop_s         = 1'b0;
      set_done_s     = 1'b0;
      consume_s      = kernel_valid_r & kernel_ready;
      full_next_s    = full_r;
      rd_bank_next_s = rd_bank_r;
      if ((state_r == ST_FILL) && weight_valid) begin
         accept_s = 1'b1;
         // The drop decision is made on the first word and held for the set.
         if (wr_idx_r == '0) begin
            drop_s = full_r[wr_bank_r];
         end else begin
            drop_s = drop_r;
         end
         if (wr_idx_r == IDX_LAST) begin
            set_done_s = 1'b1;
         end else begin
            set_done_s = 1'b0;
         end
      end else begin
         accept_s = 1'b0;
      end
      if (consume_s) begin
         full_next_s[rd_bank_r] = 1'b0;
         rd_bank_next_s         = ~rd_bank_r;
      end else begin
         rd_bank_next_s = rd_bank_r;
      end
      // Consumption and fill always target different banks.
      if (set_done_s && !drop_s) begin
         full_next_s[wr_bank_r] = 1'b1;
      end else begin
         full_next_s[wr_bank_r] = full_next_s[wr_bank_r];
      end
   end

   // Control FSM, bank bookkeeping and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         full_r         <= 2'b00;
         wr_bank_r      <= 1'b0;
         rd_bank_r      <= 1'b0;
         wr_idx_r       <= '0;
         wr_oc_r        <= '0;
         rd_oc_r        <= '0;
         drop_r         <= 1'b0;
         start_stream_r <= 1'b0;
         kernel_valid_r <= 1'b0;
         layer_done_r   <= 1'b0;
         busy_r         <= 1'b0;
         overflow_r     <= 1'b0;
      end else begin
         start_stream_r <= 1'b0;
         layer_done_r   <= 1'b0;
         // Consumer side runs in every state; IDLE overrides it below.
         full_r         <= full_next_s;
         rd_bank_r      <= rd_bank_next_s;
         kernel_valid_r <= full_next_s[rd_bank_next_s];
         if (consume_s) begin
            rd_oc_r <= rd_oc_r + OC_W'(1);
         end
         case (state_r)
            ST_IDLE: begin
               full_r         <= 2'b00;
               wr_bank_r      <= 1'b0;
               rd_bank_r      <= 1'b0;
               wr_idx_r       <= '0;
               wr_oc_r        <= '0;
               rd_oc_r        <= '0;
               drop_r         <= 1'b0;
               overflow_r     <= 1'b0;
               kernel_valid_r <= 1'b0;
               if (start_layer) begin
                  state_r        <= ST_REQ;
                  start_stream_r <= 1'b1;
                  busy_r         <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_REQ: begin
               state_r <= ST_FILL;
            end
            ST_FILL: begin
               if (accept_s) begin
                  drop_r <= drop_s;
                  if (drop_s) begin
                     overflow_r <= 1'b1;
                  end
                  if (set_done_s) begin
                     wr_bank_r <= ~wr_bank_r;
                     wr_idx_r  <= '0;
                     wr_oc_r   <= wr_oc_r + WOC_W'(1);
                     if (wr_oc_r == WOC_LAST) begin
                        state_r <= ST_DRAIN;
                     end
                  end else begin
                     wr_idx_r <= wr_idx_r + IDX_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (full_next_s == 2'b00) begin
                  layer_done_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Write accepted, non-dropped words into the current write bank.
   always_ff @(posedge clk) begin
      if (accept_s && !drop_s) begin
         bank_r[wr_bank_r][wr_idx_r] <= weight_data;
      end
   end

   // Flatten the read bank; it cannot be written while it is presented.
   always_comb begin
      kernel_data_s = '0;
      for (int e = 0; e < KPC; e++) begin
         kernel_data_s[e*DATA_WIDTH +: DATA_WIDTH] = bank_r[rd_bank_r][e];
      end
   end

`ifdef WKB_CHECKSUM_EN
   logic [31:0] checksum_r;

   // Running sign-extended sum of every accepted word, dropped ones included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum_r <= 32'd0;
      end else if (state_r == ST_REQ) begin
         checksum_r <= 32'd0;
      end else if (accept_s) begin
         checksum_r <= checksum_r +
                       {{(32-DATA_WIDTH){weight_data[DATA_WIDTH-1]}}, weight_data};
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign weight_checksum = checksum_r;
`else
   assign weight_checksum = 32'd0;
`endif

   assign start_stream = start_stream_r;
   assign kernel_valid = kernel_valid_r;
   assign kernel_data  = kernel_data_s;
   assign kernel_oc    = rd_oc_r;
   assign layer_done   = layer_done_r;
   assign busy         = busy_r;
   assign overflow     = overflow_r;

endmodule
